// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencing controller.
// Range checking is enabled by defining BCD_XS3_ERR_CHECK_EN.
package bcd_xs3_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] XS3_INVALID = 4'hF;
    localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Combinational single-digit BCD to Excess-3 converter.
// With BCD_XS3_ERR_CHECK_EN, digits above 9 map to XS3_INVALID and flag invalid.
module bcd_xs3_digit
    import bcd_xs3_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] xs3_o,
    output logic       invalid_o
);

`ifdef BCD_XS3_ERR_CHECK_EN
    always_comb begin
        invalid_o = (digit_i > BCD_MAX);
        xs3_o     = invalid_o ? XS3_INVALID : digit_i + XS3_OFFSET;
    end
`else
    // No range check: out-of-range digits simply wrap modulo 16.
    assign xs3_o     = digit_i + XS3_OFFSET;
    assign invalid_o = 1'b0;
`endif

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Multi-digit BCD to Excess-3 converter sharing one digit converter, LSD first.
// Optional range check selected by BCD_XS3_ERR_CHECK_EN (see bcd_xs3_digit).
module bcd_xs3_seq_ctrl
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  err
);

    localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] op_q, op_d;
    logic [4*DIGITS-1:0] res_q, res_d;
    logic                err_q, err_d;

    logic [3:0] dig;
    logic [3:0] dig_xs3;
    logic       dig_inv;

    assign dig = op_q[{idx_q, 2'b00} +: 4];

    bcd_xs3_digit u_digit (
        .digit_i   (dig),
        .xs3_o     (dig_xs3),
        .invalid_o (dig_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = bcd_in;
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                res_d[{idx_q, 2'b00} +: 4] = dig_xs3;
                err_d = err_q | dig_inv;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign xs3_out = res_q;
    assign err     = err_q;

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
# bcd_xs3_seq_ctrl

Sequencing controller that converts a multi-digit packed BCD word to packed Excess-3 by time-sharing a single 4-bit BCD-to-Excess-3 digit converter, one digit per clock. Sits between a requester issuing start/operand and downstream logic consuming the result on a one-cycle done pulse. Replaces a DIGITS-wide array of converters with one converter plus a small FSM.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Legal range is 1 to 16.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: conversion request. Sampled only in IDLE.
- `bcd_in` input, 4*DIGITS bits: packed BCD operand. Digit 0 is bits [3:0]. Captured on an accepted start.
- `busy` output, 1 bit: high in LOAD, CONV and DONE.
- `done` output, 1 bit: single-cycle pulse. `xs3_out` is valid in the same cycle.
- `xs3_out` output, 4*DIGITS bits: packed Excess-3 result. Held until the next accepted start.
- `err` output, 1 bit: at least one digit > 9 was seen. Valid with `done` and held with `xs3_out`.

## Operation
- FSM states: IDLE, LOAD, CONV, DONE. Encoding is defined in the package.
- IDLE: if `start`=1, capture `bcd_in` into the operand register, clear `xs3_out` and `err`, and go to LOAD. If `start`=0, stay in IDLE.
- LOAD: set digit index `idx`=0 and go to CONV. This is one cycle, reserved for the registered operand.
- CONV: apply operand digit `idx` to the shared converter. Write the converter output into result nibble `idx`.
  - If `idx`=DIGITS-1, go to DONE. Otherwise increment `idx`.
  - Digits are processed LSD first.
- DONE: assert `done` for exactly one cycle, then return to IDLE.
- Digit arithmetic: result = digit + 3, 4-bit, no carry between digits.
- `start` asserted while `busy`=1 is ignored. It is neither queued nor does it corrupt the operand.
- `bcd_in` changes after capture have no effect on the conversion in progress.
- Reset, including mid-conversion: state goes to IDLE and `idx` to 0. All outputs (`busy`, `done`, `xs3_out`, `err`) go to 0 immediately and asynchronously.
- `idx` width is clog2(DIGITS), minimum 1 bit. It never exceeds DIGITS-1.

## Timing
- Start accepted at edge T0. LOAD occupies T0..T1. CONV runs from T1 to T1+DIGITS. DONE occupies the next cycle.
- `done`=1 during the cycle after edge T0+DIGITS+1. Latency is DIGITS+2 edges from start to done deassertion.
- `busy` rises the cycle after the accepting edge. It falls together with `done`.
- Back-to-back operation: `start` held high is accepted again on the edge that enters IDLE+1. Throughput is one conversion per DIGITS+3 cycles.
- `xs3_out` and `err` are registered outputs with no combinational path from inputs.

## Configuration
- `BCD_XS3_ERR_CHECK_EN` defined:
  - A digit > 9 writes 4'hF into its result nibble.
  - It sets `err`, which is sticky until the next accepted start.
- Not defined:
  - No range check is performed.
  - Every digit is converted as (digit+3) mod 16, so 4'hA gives 4'hD.
  - `err` is tied to 0.

## Structure
- Package `bcd_xs3_pkg` holds:
  - the FSM state typedef,
  - the constant `XS3_OFFSET` = 4'd3,
  - the constant `XS3_INVALID` = 4'hF,
  - the constant `BCD_MAX` = 4'd9.
- One sub-module, `bcd_xs3_digit`: combinational single-digit converter with a 4-bit digit input, a 4-bit result output and an `invalid` flag output.
  - The controller instantiates exactly one.
  - The `BCD_XS3_ERR_CHECK_EN` handling lives in this sub-module.

## Test plan
- DIGITS=4, `bcd_in`=16'h1234, pulse `start`:
  - `xs3_out`=16'h4567 and `err`=0.
  - `done` is high exactly in cycle T0+DIGITS+1 and for one cycle only.
- `bcd_in`=16'h9999 → `xs3_out`=16'hCCCC. `bcd_in`=16'h0000 → 16'h3333.
- `bcd_in`=16'h12A4 with `BCD_XS3_ERR_CHECK_EN` defined → `xs3_out`=16'h45F7 and `err`=1. Same stimulus without the macro → 16'h45D7 and `err`=0.
- Pulse `start` again 2 cycles into a conversion with a different `bcd_in` → the first result is unchanged and exactly one `done` is produced.
- Assert `rst` during CONV with `idx`=2:
  - All outputs go to 0 before the next edge, and the FSM is in IDLE.
  - A new start of 16'h0042 afterwards yields 16'h3375.
- Hold `start` high continuously with `bcd_in`=16'h5678 → `done` pulses every DIGITS+3 cycles and `xs3_out`=16'h89AB each time.
